mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 56 +++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module      : mem_arbiter_if
// Description : Bundles the I-side, D-side and downstream line-memory buses
//               seen by the two-port memory arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
interface mem_arbiter_if #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 12,
    parameter int SEL_W  = 16
);
    // I-side (instruction fetch) port
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    // D-side (data) port
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [SEL_W-1:0]  d_sel;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    // Shared downstream memory port
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [SEL_W-1:0]  pmem_sel;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    // Environment view: the L1 caches plus the downstream memory
    modport master (
        output i_read, i_address,
        output d_read, d_write, d_address, d_wdata, d_sel,
        output pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_sel
    );

    // Arbiter view
    modport slave (
        input  i_read, i_address,
        input  d_read, d_write, d_address, d_wdata, d_sel,
        input  pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_sel
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : mem_arbiter
// Description : Grants the I-side or D-side line request to a single shared
//               lower-level memory, one registered transaction at a time, and
//               returns the line plus a one-cycle response to the granted side.
// Revision    : 1.0 - initial release
//==============================================================================
module mem_arbiter #(
    parameter int LINE_W     = 128,
    parameter int ADDR_W     = 12,
    parameter int SEL_W      = 16,
    parameter int D_PRIORITY = 0
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SERVE_I = 3'd1,
        ST_SERVE_D = 3'd2,
        ST_RESP_I  = 3'd3,
        ST_RESP_D  = 3'd4
    } state_t;

    localparam logic c_grant_i = 1'b0;
    localparam logic c_grant_d = 1'b1;

    state_t            r_state;
    logic              r_last_grant;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [ADDR_W-1:0] r_pmem_address;
    logic [LINE_W-1:0] r_pmem_wdata;
    logic [SEL_W-1:0]  r_pmem_sel;
    logic [LINE_W-1:0] r_i_rdata;
    logic              r_i_resp;
    logic [LINE_W-1:0] r_d_rdata;
    logic              r_d_resp;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_d;

    // Request decode and the IDLE grant decision: D wins when alone, always
    // under fixed priority, or when I had the previous grant.
    assign w_i_req   = bus.i_read;
    assign w_d_req   = bus.d_read | bus.d_write;
    assign w_grant_d = w_d_req & (~w_i_req | (D_PRIORITY != 0) | (r_last_grant == c_grant_i));

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_last_grant   <= c_grant_i;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_pmem_sel     <= '0;
            r_i_rdata      <= '0;
            r_i_resp       <= 1'b0;
            r_d_rdata      <= '0;
            r_d_resp       <= 1'b0;
        end else begin
            r_i_resp <= 1'b0;
            r_d_resp <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        // A simultaneous read and write is issued as a write
                        r_state        <= ST_SERVE_D;
                        r_last_grant   <= c_grant_d;
                        r_pmem_write   <= bus.d_write;
                        r_pmem_read    <= bus.d_read & ~bus.d_write;
                        r_pmem_address <= bus.d_address;
                        r_pmem_wdata   <= bus.d_wdata;
                        r_pmem_sel     <= bus.d_sel;
                    end else if (w_i_req) begin
                        r_state        <= ST_SERVE_I;
                        r_last_grant   <= c_grant_i;
                        r_pmem_write   <= 1'b0;
                        r_pmem_read    <= 1'b1;
                        r_pmem_address <= bus.i_address;
                        r_pmem_wdata   <= '0;
                        r_pmem_sel     <= '1;
                    end
                end
                ST_SERVE_I: begin
                    if (bus.pmem_resp) begin
                        r_state      <= ST_RESP_I;
                        r_i_rdata    <= bus.pmem_rdata;
                        r_i_resp     <= 1'b1;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                    end
                end
                ST_SERVE_D: begin
                    if (bus.pmem_resp) begin
                        r_state      <= ST_RESP_D;
                        r_d_rdata    <= bus.pmem_rdata;
                        r_d_resp     <= 1'b1;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                    end
                end
                // RESP states last one cycle so strobes drop between transactions
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pmem_read    = r_pmem_read;
    assign bus.pmem_write   = r_pmem_write;
    assign bus.pmem_address = r_pmem_address;
    assign bus.pmem_wdata   = r_pmem_wdata;
    assign bus.pmem_sel     = r_pmem_sel;
    assign bus.i_rdata      = r_i_rdata;
    assign bus.i_resp       = r_i_resp;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.d_resp       = r_d_resp;
endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed vector table,
//               multi-cycle corner sequences, and a randomized run checked
//               against a transaction-level model with a line memory.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_mem_arbiter;
    localparam int LINE_W = 128;
    localparam int ADDR_W = 12;
    localparam int SEL_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) bus_rr ();
    mem_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) bus_fp ();

    mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W), .D_PRIORITY(0))
        dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
    mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W), .D_PRIORITY(1))
        dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

    typedef struct {
        logic         is_d;
        logic         rd;
        logic         wr;
        logic [11:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  sel;
        int           lat;
        logic [127:0] mem_data;
        logic         exp_read;
        logic         exp_write;
        logic [15:0]  exp_sel;
        logic [127:0] exp_wdata;
    } vec_t;

    vec_t         vecs [6];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] exp_i_rdata, exp_d_rdata;
    logic [127:0] mem [4096];
    logic         exp_order [4];

    // Random-phase model state
    int           ph, lat, cnt;
    logic         last_d, srv_d, ip, dp;
    logic         t_rd, t_wr;
    logic [11:0]  t_addr;
    logic [127:0] t_wdata, t_rdata;
    logic [15:0]  t_sel;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus_rr.i_read = 1'b0; bus_rr.i_address = '0;
        bus_rr.d_read = 1'b0; bus_rr.d_write = 1'b0; bus_rr.d_address = '0;
        bus_rr.d_wdata = '0; bus_rr.d_sel = '0;
        bus_rr.pmem_resp = 1'b0; bus_rr.pmem_rdata = '0;
        bus_fp.i_read = 1'b0; bus_fp.i_address = '0;
        bus_fp.d_read = 1'b0; bus_fp.d_write = 1'b0; bus_fp.d_address = '0;
        bus_fp.d_wdata = '0; bus_fp.d_sel = '0;
        bus_fp.pmem_resp = 1'b0; bus_fp.pmem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, " ctl"}, {bus_rr.pmem_read, bus_rr.pmem_write, bus_rr.pmem_address,
                               bus_rr.pmem_sel, bus_rr.i_resp, bus_rr.d_resp}, '0);
        check({name, " wdata"}, bus_rr.pmem_wdata, '0);
        check({name, " rdata"}, {bus_rr.i_rdata[63:0], bus_rr.d_rdata[63:0]}, '0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        if (v.is_d) begin
            bus_rr.d_read = v.rd; bus_rr.d_write = v.wr; bus_rr.d_address = v.addr;
            bus_rr.d_wdata = v.wdata; bus_rr.d_sel = v.sel;
        end else begin
            bus_rr.i_read = 1'b1; bus_rr.i_address = v.addr;
        end
        tick();
        check($sformatf("vec%0d issue", idx),
              {bus_rr.i_resp, bus_rr.d_resp, bus_rr.pmem_read, bus_rr.pmem_write, bus_rr.pmem_address, bus_rr.pmem_sel},
              {2'b00, v.exp_read, v.exp_write, v.addr, v.exp_sel});
        check($sformatf("vec%0d wdata", idx), bus_rr.pmem_wdata, v.exp_wdata);
        for (int k = 1; k < v.lat; k++) begin
            tick();
            check($sformatf("vec%0d hold%0d", idx, k),
                  {bus_rr.i_resp, bus_rr.d_resp, bus_rr.pmem_read, bus_rr.pmem_write, bus_rr.pmem_address},
                  {2'b00, v.exp_read, v.exp_write, v.addr});
        end
        bus_rr.pmem_resp = 1'b1;
        bus_rr.pmem_rdata = v.mem_data;
        bus_rr.i_read = 1'b0; bus_rr.d_read = 1'b0; bus_rr.d_write = 1'b0;
        tick();
        bus_rr.pmem_resp = 1'b0;
        bus_rr.pmem_rdata = '1;
        if (v.is_d) exp_d_rdata = v.mem_data;
        else        exp_i_rdata = v.mem_data;
        check($sformatf("vec%0d resp", idx), {bus_rr.i_resp, bus_rr.d_resp, bus_rr.pmem_read, bus_rr.pmem_write},
              {~v.is_d, v.is_d, 2'b00});
        check($sformatf("vec%0d i_rdata", idx), bus_rr.i_rdata, exp_i_rdata);
        check($sformatf("vec%0d d_rdata", idx), bus_rr.d_rdata, exp_d_rdata);
        tick();
        check($sformatf("vec%0d one pulse", idx), {bus_rr.i_resp, bus_rr.d_resp}, 2'b00);
    endtask

    task automatic new_i();
        bus_rr.i_read = 1'b1;
        bus_rr.i_address = {1'b0, 11'($urandom)};
    endtask

    task automatic new_d();
        int op;
        op = int'($urandom_range(0, 2));
        bus_rr.d_read = (op != 1);
        bus_rr.d_write = (op != 0);
        bus_rr.d_address = {1'b1, 11'($urandom)};
        bus_rr.d_wdata = {$urandom, $urandom, $urandom, $urandom};
        bus_rr.d_sel = 16'($urandom);
    endtask

    initial begin
        //        is_d rd   wr   addr     wdata           sel       lat mem_data                                    rd   wr   exp_sel   exp_wdata
        vecs[0] = '{1'b0, 1'b1, 1'b0, 12'h0A3, 128'h0,       16'h0000, 4, 128'h0123456789ABCDEF00112233DEADBEEF, 1'b1, 1'b0, 16'hFFFF, 128'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 12'h100, 128'h1234,    16'h0003, 2, 128'h77,                              1'b0, 1'b1, 16'h0003, 128'h1234};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 12'h7FF, 128'hCAFE,    16'hFFFF, 1, 128'hA5A5_0000_FFFF_1111,            1'b1, 1'b0, 16'hFFFF, 128'hCAFE};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 12'h200, 128'h55AA,    16'h00F0, 3, 128'h3C3C,                            1'b0, 1'b1, 16'h00F0, 128'h55AA};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 12'hFFF, 128'h0,       16'h0000, 1, {4{32'h600DF00D}},                    1'b1, 1'b0, 16'hFFFF, 128'h0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 12'h000, 128'h0,       16'h0000, 2, 128'h1,                               1'b1, 1'b0, 16'hFFFF, 128'h0};
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};

        do_reset();
        check_all_zero("reset state");

        // Directed single transactions from the table
        for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

        // Round-robin contention from reset: D, I, D, I
        do_reset();
        bus_rr.i_read = 1'b1; bus_rr.i_address = 12'h011;
        bus_rr.d_read = 1'b1; bus_rr.d_address = 12'h822; bus_rr.d_sel = 16'hFFFF;
        for (int t = 0; t < 4; t++) begin
            tick();
            check($sformatf("rr grant%0d addr", t), {bus_rr.pmem_read, bus_rr.pmem_address},
                  {1'b1, exp_order[t] ? 12'h822 : 12'h011});
            bus_rr.pmem_resp = 1'b1;
            bus_rr.pmem_rdata = 128'(t + 100);
            if (t == 3) begin bus_rr.i_read = 1'b0; bus_rr.d_read = 1'b0; end
            tick();
            bus_rr.pmem_resp = 1'b0;
            check($sformatf("rr resp%0d", t), {bus_rr.i_resp, bus_rr.d_resp}, {~exp_order[t], exp_order[t]});
            check($sformatf("rr rdata%0d", t), exp_order[t] ? bus_rr.d_rdata : bus_rr.i_rdata, 128'(t + 100));
            tick();
            check($sformatf("rr gap%0d", t), {bus_rr.pmem_read, bus_rr.pmem_write}, 2'b00);
        end
        tick();
        check("rr idle after", {bus_rr.pmem_read, bus_rr.pmem_write}, 2'b00);

        // Requester changes inputs while being served
        bus_rr.d_read = 1'b1; bus_rr.d_address = 12'h055; bus_rr.d_sel = 16'hFFFF;
        tick();
        check("midchg grant", {bus_rr.pmem_read, bus_rr.pmem_write, bus_rr.pmem_address}, {2'b10, 12'h055});
        bus_rr.d_address = 12'h066; bus_rr.d_read = 1'b0; bus_rr.d_write = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("midchg hold%0d", k), {bus_rr.pmem_read, bus_rr.pmem_write, bus_rr.pmem_address},
                  {2'b10, 12'h055});
        end
        bus_rr.pmem_resp = 1'b1; bus_rr.pmem_rdata = 128'hBEEF; bus_rr.d_write = 1'b0;
        tick();
        bus_rr.pmem_resp = 1'b0;
        check("midchg resp", {bus_rr.d_resp, bus_rr.d_rdata}, {1'b1, 128'hBEEF});
        tick();

        // Reset in SERVE_I followed by a stray downstream response
        bus_rr.i_read = 1'b1; bus_rr.i_address = 12'h0A3;
        tick();
        check("rstmid serving", bus_rr.pmem_read, 1'b1);
        rst = 1'b1;
        tick();
        check_all_zero("rstmid after rst");
        rst = 1'b0; bus_rr.i_read = 1'b0;
        exp_i_rdata = '0; exp_d_rdata = '0;
        tick();
        bus_rr.pmem_resp = 1'b1; bus_rr.pmem_rdata = 128'hFACE;
        tick();
        bus_rr.pmem_resp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rstmid quiet%0d", k),
                  {bus_rr.i_resp, bus_rr.d_resp, bus_rr.pmem_read, bus_rr.pmem_write, bus_rr.i_rdata}, '0);
            tick();
        end

        // Fixed priority: D keeps winning while it re-requests, then I is served
        do_reset();
        bus_fp.i_read = 1'b1; bus_fp.i_address = 12'h0AA;
        bus_fp.d_read = 1'b1; bus_fp.d_address = 12'h8BB; bus_fp.d_sel = 16'hFFFF;
        for (int t = 0; t < 3; t++) begin
            tick();
            check($sformatf("fp grant%0d", t), {bus_fp.pmem_read, bus_fp.pmem_address}, {1'b1, 12'h8BB});
            bus_fp.pmem_resp = 1'b1; bus_fp.pmem_rdata = 128'(t + 7);
            tick();
            bus_fp.pmem_resp = 1'b0; bus_fp.d_read = 1'b0;
            check($sformatf("fp resp%0d", t), {bus_fp.i_resp, bus_fp.d_resp}, 2'b01);
            tick();
            check($sformatf("fp gap%0d", t), {bus_fp.pmem_read, bus_fp.pmem_write}, 2'b00);
            if (t < 2) bus_fp.d_read = 1'b1;
        end
        tick();
        check("fp i grant", {bus_fp.pmem_read, bus_fp.pmem_address}, {1'b1, 12'h0AA});
        bus_fp.pmem_resp = 1'b1; bus_fp.pmem_rdata = 128'h1D1D;
        tick();
        bus_fp.pmem_resp = 1'b0; bus_fp.i_read = 1'b0;
        check("fp i resp", {bus_fp.i_resp, bus_fp.d_resp, bus_fp.i_rdata}, {2'b10, 128'h1D1D});
        tick();

        // Randomized traffic against a transaction-level model with a line memory.
        // I addresses have bit 11 clear and D addresses bit 11 set.
        for (int a = 0; a < 4096; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
        do_reset();
        ph = 0; last_d = 1'b0; srv_d = 1'b0; lat = 1; cnt = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            check("rnd resp exclusive", bus_rr.i_resp & bus_rr.d_resp, 1'b0);
            if (ph == 0) begin
                check("rnd idle quiet", {bus_rr.pmem_read, bus_rr.pmem_write, bus_rr.i_resp, bus_rr.d_resp}, 4'b0);
                if (!bus_rr.i_read && $urandom_range(0, 2) == 0) new_i();
                if (!(bus_rr.d_read | bus_rr.d_write) && $urandom_range(0, 2) == 0) new_d();
                ip = bus_rr.i_read;
                dp = bus_rr.d_read | bus_rr.d_write;
                if (ip || dp) begin
                    srv_d  = dp && (!ip || !last_d);
                    last_d = srv_d;
                    if (srv_d) begin
                        t_wr = bus_rr.d_write; t_rd = bus_rr.d_read & ~bus_rr.d_write;
                        t_addr = bus_rr.d_address; t_wdata = bus_rr.d_wdata; t_sel = bus_rr.d_sel;
                    end else begin
                        t_wr = 1'b0; t_rd = 1'b1;
                        t_addr = bus_rr.i_address; t_wdata = '0; t_sel = 16'hFFFF;
                    end
                    lat = int'($urandom_range(1, 4)); cnt = 0; ph = 1;
                end
            end else if (ph == 1) begin
                check("rnd pmem ctl", {bus_rr.i_resp, bus_rr.d_resp, bus_rr.pmem_read, bus_rr.pmem_write,
                                       bus_rr.pmem_address, bus_rr.pmem_sel}, {2'b00, t_rd, t_wr, t_addr, t_sel});
                check("rnd pmem wdata", bus_rr.pmem_wdata, t_wdata);
                cnt++;
                if (cnt == lat) begin
                    t_rdata = mem[t_addr];
                    bus_rr.pmem_resp = 1'b1; bus_rr.pmem_rdata = t_rdata;
                    if (t_wr) for (int b = 0; b < 16; b++) if (t_sel[b]) mem[t_addr][8*b +: 8] = t_wdata[8*b +: 8];
                    ph = 2;
                end else if ($urandom_range(0, 3) == 0) begin
                    if (srv_d) new_d(); else new_i();
                end
            end else begin
                bus_rr.pmem_resp = 1'b0; bus_rr.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
                if (srv_d) exp_d_rdata = t_rdata; else exp_i_rdata = t_rdata;
                check("rnd resp", {bus_rr.i_resp, bus_rr.d_resp, bus_rr.pmem_read, bus_rr.pmem_write},
                      {~srv_d, srv_d, 2'b00});
                check("rnd i_rdata", bus_rr.i_rdata, exp_i_rdata);
                check("rnd d_rdata", bus_rr.d_rdata, exp_d_rdata);
                if (srv_d) begin
                    if ($urandom_range(0, 1) == 0) new_d();
                    else begin bus_rr.d_read = 1'b0; bus_rr.d_write = 1'b0; end
                end else begin
                    if ($urandom_range(0, 1) == 0) new_i();
                    else bus_rr.i_read = 1'b0;
                end
                ph = 0;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
